dist_ram_bw: RTL

Parametrised distributed RAM with one write port and one read port. Adds three things the team's earlier asynchronous distributed RAM does not have:

- per-byte write enables;
- selectable read latency (0 or 1) with a defined read-during-write mode;
- a hardware clear sequencer that zeroes every location after reset, instead of relying on an `initial` block.

It is used as a register file, small lookup table or scratch buffer in datapaths where the memory must be zero after every reset, not only at power-up.

---
 rtl/dist_ram_pkg.sv | 38 +++
 rtl/dist_ram_bw_if.sv | 32 +++
 rtl/dist_ram_clr_seq.sv | 43 ++++
 rtl/dist_ram_bw.sv | 99 +++++++++
 4 files changed

// File: rtl/dist_ram_pkg.sv
// Shared declarations for the byte-writable distributed RAM.
//   state_t     : clear sequencer states (ST_CLEAR, ST_READY)
//   RDW_OLD/NEW : same-address read-during-write selection
//   be_merge()  : byte-enable merge shared by the write path and the bypass path
package dist_ram_pkg;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_READY = 1'b1
    } state_t;

    localparam int RDW_OLD = 0;
    localparam int RDW_NEW = 1;

    // Widest word be_merge() handles; callers zero-extend into this width
    // and truncate the result back to their own word width.
    localparam int MERGE_WIDTH = 256;

    // Bit i of the result takes new_word[i] when the enable of the byte that
    // contains bit i is set, otherwise keeps old_word[i]. byte_width is a
    // constant at every call site, so the loop folds to plain muxes.
    function automatic logic [MERGE_WIDTH-1:0] be_merge(
        input logic [MERGE_WIDTH-1:0] old_word,
        input logic [MERGE_WIDTH-1:0] new_word,
        input logic [MERGE_WIDTH-1:0] be,
        input int                     byte_width
    );
        logic [MERGE_WIDTH-1:0] res;
        res = old_word;
        for (int i = 0; i < MERGE_WIDTH; i++) begin
            if (be[i / byte_width]) begin
                res[i] = new_word[i];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/dist_ram_bw_if.sv
// Request/response bundle of dist_ram_bw.
//   write, write_addr, write_be, data_in : write port (master drives)
//   read, read_addr                      : read request (master drives)
//   data_out, read_valid, busy           : read result and clear status (slave drives)
interface dist_ram_bw_if #(
    parameter int DATA_WIDTH = 32,
    parameter int BYTE_WIDTH = 8,
    parameter int ADDR_WIDTH = 6
);
    localparam int NB = DATA_WIDTH / BYTE_WIDTH;

    logic                  write;
    logic [ADDR_WIDTH-1:0] write_addr;
    logic [NB-1:0]         write_be;
    logic [DATA_WIDTH-1:0] data_in;
    logic                  read;
    logic [ADDR_WIDTH-1:0] read_addr;
    logic [DATA_WIDTH-1:0] data_out;
    logic                  read_valid;
    logic                  busy;

    modport master (
        output write, write_addr, write_be, data_in, read, read_addr,
        input  data_out, read_valid, busy
    );

    modport slave (
        input  write, write_addr, write_be, data_in, read, read_addr,
        output data_out, read_valid, busy
    );

endinterface

// File: rtl/dist_ram_clr_seq.sv
// Clear sequencer: after every reset, walks clr_addr over 0..DEPTH-1 (one
// location per clock) and then releases the RAM to the user.
//   clk, rst : clock, synchronous active-high reset (restarts the walk)
//   busy     : clear in progress or reset asserted; user requests are ignored
//   clr_we   : write zero to clr_addr on this edge
//   clr_addr : location being cleared
module dist_ram_clr_seq
    import dist_ram_pkg::*;
#(
    parameter int ADDR_WIDTH = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic                  busy,
    output logic                  clr_we,
    output logic [ADDR_WIDTH-1:0] clr_addr
);

    // One spare MSB so the counter never wraps back onto address 0.
    localparam logic [ADDR_WIDTH:0] LAST = {1'b0, {ADDR_WIDTH{1'b1}}};

    state_t              state;
    logic [ADDR_WIDTH:0] cnt;

    // NOTE: state registers use non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_CLEAR;
            cnt   <= '0;
        end else if (state == ST_CLEAR) begin
            cnt <= cnt + (ADDR_WIDTH+1)'(1);
            if (cnt == LAST) begin
                state <= ST_READY;
            end
        end
    end

    assign busy     = rst | (state == ST_CLEAR);
    assign clr_we   = ~rst & (state == ST_CLEAR);
    assign clr_addr = cnt[ADDR_WIDTH-1:0];

endmodule

// File: rtl/dist_ram_bw.sv
// Distributed RAM, one write port with byte enables and one read port with
// selectable latency (0 = combinational, 1 = registered). Contents are
// zeroed by a hardware sweep after every reset.
//   clk, rst : clock, synchronous active-high reset
//   bus      : dist_ram_bw_if slave (write/read requests, data_out,
//              read_valid, busy)
module dist_ram_bw
    import dist_ram_pkg::*;
#(
    parameter int DATA_WIDTH   = 32,
    parameter int BYTE_WIDTH   = 8,
    parameter int ADDR_WIDTH   = 6,
    parameter int READ_LATENCY = 0,
    parameter int RDW_MODE     = RDW_OLD
) (
    input  logic            clk,
    input  logic            rst,
    dist_ram_bw_if.slave    bus
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    if ((DATA_WIDTH % BYTE_WIDTH) != 0 || DATA_WIDTH > MERGE_WIDTH) begin : g_bad_width
        $error("dist_ram_bw: DATA_WIDTH must be a multiple of BYTE_WIDTH and at most MERGE_WIDTH");
    end

    logic                  busy;
    logic                  clr_we;
    logic [ADDR_WIDTH-1:0] clr_addr;

    dist_ram_clr_seq #(
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_clr_seq (
        .clk      (clk),
        .rst      (rst),
        .busy     (busy),
        .clr_we   (clr_we),
        .clr_addr (clr_addr)
    );

    // NOTE: the array has no reset branch; a reset term would turn every
    // word into resettable flops. The clear sweep zeroes it instead.
    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic                  wr_en;
    logic [DATA_WIDTH-1:0] wr_word;
    logic                  bypass;
    logic [DATA_WIDTH-1:0] rd_word;

    assign wr_en   = bus.write & ~busy;
    assign wr_word = DATA_WIDTH'(be_merge(MERGE_WIDTH'(mem[bus.write_addr]),
                                          MERGE_WIDTH'(bus.data_in),
                                          MERGE_WIDTH'(bus.write_be),
                                          BYTE_WIDTH));

    // Clear and user writes never coincide: user writes are gated by busy.
    always_ff @(posedge clk) begin
        if (clr_we) begin
            mem[clr_addr] <= '0;
        end else if (wr_en) begin
            mem[bus.write_addr] <= wr_word;
        end
    end

    // Same-address bypass: the merged word already uses the stored word of
    // that address as its base, so it is exactly the post-write contents.
    assign bypass  = (RDW_MODE == RDW_NEW) && wr_en && (bus.write_addr == bus.read_addr);
    assign rd_word = bypass ? wr_word : mem[bus.read_addr];

    if (READ_LATENCY == 0) begin : g_lat0
        assign bus.data_out   = busy ? '0 : rd_word;
        assign bus.read_valid = bus.read & ~busy;
    end else if (READ_LATENCY == 1) begin : g_lat1
        logic [DATA_WIDTH-1:0] rd_q;
        logic                  rv_q;

        always_ff @(posedge clk) begin
            if (busy) begin
                rd_q <= '0;
                rv_q <= 1'b0;
            end else if (bus.read) begin
                rd_q <= rd_word;
                rv_q <= 1'b1;
            end else begin
                rv_q <= 1'b0;
            end
        end

        // Masking keeps outputs at zero from the first cycle rst is high,
        // before the registers have seen a reset edge.
        assign bus.data_out   = busy ? '0 : rd_q;
        assign bus.read_valid = rv_q & ~busy;
    end else begin : g_bad_latency
        $error("dist_ram_bw: READ_LATENCY must be 0 or 1");
    end

    assign bus.busy = busy;

endmodule
